// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared FSM encoding, init ROM and DDRAM constants for lcd_seq
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    INIT     = 3'd1,
    GAP      = 3'd2,
    ROW_ADDR = 3'd3,
    ROW_CHAR = 3'd4,
    NEXT     = 3'd5
  } lcd_state_t;

  localparam int         INIT_LEN    = 8;
  localparam logic [2:0] LAST_INIT   = 3'(INIT_LEN - 1);
  localparam logic [2:0] GAP_ENTRIES = 3'd3;
  localparam int         RS_BIT      = 8;
  localparam logic [7:0] ROW0_BASE   = 8'h80;
  localparam logic [7:0] ROW1_BASE   = 8'hC0;
  localparam logic [7:0] BLANK_CHAR  = 8'h20;

  // HD44780 8-bit wake-up: three bare function sets, then configure
  function automatic logic [8:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: init_rom = 9'h038;
      3'd4:                   init_rom = 9'h008;
      3'd5:                   init_rom = 9'h001;
      3'd6:                   init_rom = 9'h006;
      default:                init_rom = 9'h00C;
    endcase
  endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// rtl/lcd_char_buf.sv - 2x16 character shadow buffer, one write port, combinational read
module lcd_char_buf
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem [32];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) mem[i] <= BLANK_CHAR;
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/lcd_seq.sv
// rtl/lcd_seq.sv - LCD init + shadow-buffer refresh sequencer; LCD_DIRTY_REFRESH_EN enables dirty-row refresh
module lcd_seq
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYCLES = 1500000,
  parameter int GAP_CYCLES   = 410000,
  parameter int COLS         = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  output logic [8:0] cmd_o,
  output logic       cmd_valid_o,
  input  logic       drv_ready_i,
  input  logic       buf_we_i,
  input  logic [4:0] buf_addr_i,
  input  logic [7:0] buf_data_i,
  output logic       init_done_o,
  output logic       busy_o
);

  localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_COL   = 4'(COLS - 1);

  lcd_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic             row, row_n;
  logic [3:0]       col, col_n;
  logic             done_n;
  logic             xfer, issue;
  logic [8:0]       cmd_n;
  logic [7:0]       rd_data;

  assign xfer = cmd_valid_o & drv_ready_i;

  lcd_char_buf u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (buf_we_i),
    .waddr_i (buf_addr_i),
    .wdata_i (buf_data_i),
    .raddr_i ({row_n, col_n}),
    .rdata_o (rd_data)
  );

`ifdef LCD_DIRTY_REFRESH_EN
  logic [1:0] dirty, dirty_set, dirty_clr;

  assign dirty_set = buf_we_i ? (buf_addr_i[4] ? 2'b10 : 2'b01) : 2'b00;
  assign dirty_clr = (state_n == ROW_ADDR && state != ROW_ADDR) ? (row_n ? 2'b10 : 2'b01) : 2'b00;

  // A write landing on the entry edge wins, so that row is sent once more
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) dirty <= 2'b11;
    else          dirty <= (dirty & ~dirty_clr) | dirty_set;
  end

  assign busy_o = !(state == NEXT && dirty == 2'b00);
`else
  assign busy_o = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    row_n   = row;
    col_n   = col;
    done_n  = init_done_o;
    case (state)
      PWR_WAIT: begin
        if (cnt >= PWRUP_LAST) begin
          state_n = INIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      INIT: begin
        if (xfer) begin
          if (idx == LAST_INIT) begin
            done_n  = 1'b1;
            state_n = ROW_ADDR;
            row_n   = 1'b0;
          end else begin
            idx_n = idx + 1'b1;
            if (idx < GAP_ENTRIES) begin
              state_n = GAP;
              cnt_n   = '0;
            end
          end
        end
      end
      GAP: begin
        if (cnt >= GAP_LAST) begin
          state_n = INIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ROW_ADDR: begin
        if (xfer) begin
          state_n = ROW_CHAR;
          col_n   = 4'd0;
        end
      end
      ROW_CHAR: begin
        if (xfer) begin
          if (col == LAST_COL) state_n = NEXT;
          else                 col_n   = col + 1'b1;
        end
      end
      NEXT: begin
`ifdef LCD_DIRTY_REFRESH_EN
        if (dirty[0]) begin
          state_n = ROW_ADDR;
          row_n   = 1'b0;
        end else if (dirty[1]) begin
          state_n = ROW_ADDR;
          row_n   = 1'b1;
        end
`else
        state_n = ROW_ADDR;
        row_n   = ~row;
`endif
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  // New command only once valid has dropped and the driver shows ready again
  always_comb begin
    issue = 1'b0;
    cmd_n = cmd_o;
    if (!cmd_valid_o && drv_ready_i) begin
      case (state_n)
        INIT: begin
          issue = 1'b1;
          cmd_n = init_rom(idx_n);
        end
        ROW_ADDR: begin
          issue = 1'b1;
          cmd_n = {1'b0, (row_n ? ROW1_BASE : ROW0_BASE)};
        end
        ROW_CHAR: begin
          issue         = 1'b1;
          cmd_n         = {1'b0, rd_data};
          cmd_n[RS_BIT] = 1'b1;
        end
        default: issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= PWR_WAIT;
      cnt         <= '0;
      idx         <= 3'd0;
      row         <= 1'b0;
      col         <= 4'd0;
      init_done_o <= 1'b0;
      cmd_o       <= 9'h000;
      cmd_valid_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      row         <= row_n;
      col         <= col_n;
      init_done_o <= done_n;
      cmd_valid_o <= issue | (cmd_valid_o & ~xfer);
      if (issue) cmd_o <= cmd_n;
    end
  end

endmodule

// File: tb/tb_lcd_seq.sv
// tb/tb_lcd_seq.sv - directed self-checking bench for lcd_seq (PWRUP_CYCLES=20, GAP_CYCLES=10)
module tb_lcd_seq;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [8:0] cmd_o;
  logic       cmd_valid_o;
  logic       drv_ready_i;
  logic       buf_we_i;
  logic [4:0] buf_addr_i;
  logic [7:0] buf_data_i;
  logic       init_done_o;
  logic       busy_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int low_cnt = 0;
  logic [8:0] xlog[$];
  int         xcyc[$];
  logic [8:0] exp_q[$];
  logic [7:0] shadow [32];

  lcd_seq #(.PWRUP_CYCLES(20), .GAP_CYCLES(10), .COLS(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cmd_o       (cmd_o),
    .cmd_valid_o (cmd_valid_o),
    .drv_ready_i (drv_ready_i),
    .buf_we_i    (buf_we_i),
    .buf_addr_i  (buf_addr_i),
    .buf_data_i  (buf_data_i),
    .init_done_o (init_done_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Sample at the falling edge, log a pending transfer, advance one cycle, then update the driver model
  task automatic tick();
    logic x;
    x = cmd_valid_o && drv_ready_i;
    if (x) begin
      xlog.push_back(cmd_o);
      xcyc.push_back(cyc);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (ready_mode == 1) begin
      if (x) low_cnt = 5;
      if (low_cnt > 0) begin
        drv_ready_i = 1'b0;
        low_cnt--;
      end else begin
        drv_ready_i = 1'b1;
      end
    end else begin
      drv_ready_i = 1'b1;
    end
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int b = budget;
    while (xlog.size() < n && b > 0) begin
      tick();
      b--;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    buf_we_i   = 1'b1;
    buf_addr_i = a;
    buf_data_i = d;
    shadow[a]  = d;
    tick();
    buf_we_i = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n_i     = 1'b0;
    buf_we_i    = 1'b0;
    drv_ready_i = 1'b1;
    low_cnt     = 0;
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc = 0;
    xlog.delete();
    xcyc.delete();
  endtask

  task automatic push_init_exp();
    logic [8:0] rom [8] = '{9'h038, 9'h038, 9'h038, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
    for (int i = 0; i < 8; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic push_row_exp(input logic r);
    exp_q.push_back(r ? 9'h0C0 : 9'h080);
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, shadow[{r, 4'(c)}]});
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    n_chk++; if (cmd_o !== 9'h000) begin n_fail++; $display("FAIL reset_cmd: got %h, required 000", cmd_o); end
    n_chk++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", cmd_valid_o); end
    n_chk++; if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b, required 0", init_done_o); end
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b, required 1", busy_o); end
  endtask

  task automatic test_init_sequence();
    int exp_cyc [8] = '{20, 31, 42, 53, 55, 57, 59, 61};
    apply_reset();
    repeat (19) tick();
    n_chk++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL pwrup_early_valid: got %b at cycle %0d, required 0", cmd_valid_o, cyc); end
    tick();
    n_chk++; if (cmd_valid_o !== 1'b1 || cmd_o !== 9'h038) begin n_fail++; $display("FAIL pwrup_first_cmd: got valid=%b cmd=%h at cycle 20, required valid=1 cmd=038", cmd_valid_o, cmd_o); end
    wait_xfers(7, 200);
    n_chk++; if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %b, required 0", init_done_o); end
    wait_xfers(8, 50);
    n_chk++; if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL init_done_set: got %b, required 1", init_done_o); end
    exp_q.delete();
    push_init_exp();
    for (int i = 0; i < 8; i++) begin
      logic [8:0] got_c = (i < xlog.size()) ? xlog[i] : 9'h1FF;
      int         got_t = (i < xcyc.size()) ? xcyc[i] : -1;
      n_chk++; if (got_c !== exp_q[i]) begin n_fail++; $display("FAIL init_cmd[%0d]: got %h, required %h", i, got_c, exp_q[i]); end
      n_chk++; if (got_t != exp_cyc[i]) begin n_fail++; $display("FAIL init_timing[%0d]: got cycle %0d, required %0d", i, got_t, exp_cyc[i]); end
    end
  endtask

  task automatic test_driver_handshake();
    int exp_gap [7] = '{11, 11, 11, 7, 7, 7, 7};
    int b = 1000;
    apply_reset();
    ready_mode = 1;
    while (xlog.size() < 8 && b > 0) begin
      logic       hold = cmd_valid_o && !drv_ready_i;
      logic [8:0] pc   = cmd_o;
      tick();
      b--;
      if (hold) begin
        n_chk++; if (cmd_valid_o !== 1'b1 || cmd_o !== pc) begin n_fail++; $display("FAIL hold_stable: got valid=%b cmd=%h, required valid=1 cmd=%h", cmd_valid_o, cmd_o, pc); end
      end
    end
    ready_mode = 0;
    exp_q.delete();
    push_init_exp();
    n_chk++; if (xlog.size() != 8) begin n_fail++; $display("FAIL handshake_count: got %0d transfers, required 8", xlog.size()); end
    for (int i = 0; i < 8 && i < xlog.size(); i++) begin
      n_chk++; if (xlog[i] !== exp_q[i]) begin n_fail++; $display("FAIL handshake_cmd[%0d]: got %h, required %h", i, xlog[i], exp_q[i]); end
    end
    for (int i = 0; i < 7 && i + 1 < xcyc.size(); i++) begin
      n_chk++; if (xcyc[i+1] - xcyc[i] != exp_gap[i]) begin n_fail++; $display("FAIL handshake_spacing[%0d]: got %0d, required %0d", i, xcyc[i+1] - xcyc[i], exp_gap[i]); end
    end
  endtask

  task automatic test_buffer_rows();
    apply_reset();
    wr(5'd0, 8'h41);
    wr(5'd31, 8'h5A);
    wait_xfers(42, 3000);
    n_chk++; if (xlog.size() < 42) begin n_fail++; $display("FAIL rows_timeout: got %0d transfers, required 42", xlog.size()); end
    exp_q.delete();
    push_row_exp(1'b0);
    push_row_exp(1'b1);
    for (int i = 0; i < 34; i++) begin
      logic [8:0] got = (8 + i < xlog.size()) ? xlog[8+i] : 9'h1FF;
      n_chk++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL rows_stream[%0d]: got %h, required %h", i, got, exp_q[i]); end
    end
    if (xlog.size() >= 42) begin
      n_chk++; if (xlog[9] !== 9'h141 || xlog[41] !== 9'h15A) begin n_fail++; $display("FAIL rows_corners: got %h/%h, required 141/15A", xlog[9], xlog[41]); end
    end
  endtask

`ifdef LCD_DIRTY_REFRESH_EN
  task automatic test_dirty_idle();
    int base;
    int seen_valid = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_valid_o) seen_valid++;
    end
    n_chk++; if (seen_valid != 0) begin n_fail++; $display("FAIL idle_valid: got %0d valid cycles, required 0", seen_valid); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", busy_o); end
    base = xlog.size();
    wr(5'd17, 8'h31);
    wait_xfers(base + 17, 500);
    repeat (30) tick();
    n_chk++; if (xlog.size() != base + 17) begin n_fail++; $display("FAIL dirty_row1_count: got %0d, required %0d", xlog.size(), base + 17); end
    exp_q.delete();
    push_row_exp(1'b1);
    for (int i = 0; i < 17; i++) begin
      logic [8:0] got = (base + i < xlog.size()) ? xlog[base+i] : 9'h1FF;
      n_chk++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL dirty_row1[%0d]: got %h, required %h", i, got, exp_q[i]); end
    end
    if (xlog.size() > base + 2) begin
      n_chk++; if (xlog[base+2] !== 9'h131) begin n_fail++; $display("FAIL dirty_row1_col1: got %h, required 131", xlog[base+2]); end
    end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dirty_busy_after: got %b, required 0", busy_o); end
  endtask

  task automatic test_dirty_rewrite();
    int base = xlog.size();
    int b = 500;
    exp_q.delete();
    wr(5'd0, 8'h42);
    push_row_exp(1'b0);
    while (!(xlog.size() >= base + 9 && cmd_valid_o) && b > 0) begin
      tick();
      b--;
    end
    n_chk++; if (cmd_o !== 9'h120) begin n_fail++; $display("FAIL rewrite_presented_col8: got %h, required 120", cmd_o); end
    wr(5'd8, 8'h38);
    n_chk++; if (xlog.size() < base + 10 || xlog[base+9] !== 9'h120) begin n_fail++; $display("FAIL rewrite_col8_held: got %0d transfers, required col 8 sent as 120", xlog.size() - base); end
    push_row_exp(1'b0);
    wait_xfers(base + 34, 500);
    repeat (20) tick();
    n_chk++; if (xlog.size() != base + 34) begin n_fail++; $display("FAIL rewrite_count: got %0d, required %0d", xlog.size() - base, 34); end
    for (int i = 0; i < 34; i++) begin
      logic [8:0] got = (base + i < xlog.size()) ? xlog[base+i] : 9'h1FF;
      n_chk++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL rewrite_stream[%0d]: got %h, required %h", i, got, exp_q[i]); end
    end
  endtask
`else
  task automatic test_alternate();
    int base = xlog.size();
    wait_xfers(base + 17, 500);
    exp_q.delete();
    push_row_exp(1'b0);
    for (int i = 0; i < 17; i++) begin
      logic [8:0] got = (base + i < xlog.size()) ? xlog[base+i] : 9'h1FF;
      n_chk++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL alternate_row0[%0d]: got %h, required %h", i, got, exp_q[i]); end
    end
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL alternate_busy: got %b, required 1", busy_o); end
  endtask
`endif

  task automatic test_reset_mid_row();
    int base = xlog.size();
    int b = 500;
    wr(5'd16, 8'h44);
    while (!(xlog.size() >= base + 5 && cmd_valid_o) && b > 0) begin
      tick();
      b--;
    end
    n_chk++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL midrow_reach: got valid=%b, required 1", cmd_valid_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_chk++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b, required 0", cmd_valid_o); end
    n_chk++; if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL async_init_done: got %b, required 0", init_done_o); end
    n_chk++; if (cmd_o !== 9'h000) begin n_fail++; $display("FAIL async_cmd: got %h, required 000", cmd_o); end
    @(negedge clk_i);
    apply_reset();
    repeat (19) tick();
    n_chk++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL restart_early_valid: got %b, required 0", cmd_valid_o); end
    tick();
    n_chk++; if (cmd_valid_o !== 1'b1 || cmd_o !== 9'h038) begin n_fail++; $display("FAIL restart_first_cmd: got valid=%b cmd=%h, required valid=1 cmd=038", cmd_valid_o, cmd_o); end
    wait_xfers(25, 2000);
    exp_q.delete();
    push_init_exp();
    exp_q.push_back(9'h080);
    for (int c = 0; c < 16; c++) exp_q.push_back(9'h120);
    for (int i = 0; i < 25; i++) begin
      logic [8:0] got = (i < xlog.size()) ? xlog[i] : 9'h1FF;
      n_chk++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL restart_stream[%0d]: got %h, required %h", i, got, exp_q[i]); end
    end
    n_chk++; if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL restart_init_done: got %b, required 1", init_done_o); end
  endtask

  initial begin
    rst_n_i     = 1'b0;
    drv_ready_i = 1'b1;
    buf_we_i    = 1'b0;
    buf_addr_i  = 5'd0;
    buf_data_i  = 8'h00;
    @(negedge clk_i);
    test_reset();
    test_init_sequence();
    test_driver_handshake();
    test_buffer_rows();
`ifdef LCD_DIRTY_REFRESH_EN
    test_dirty_idle();
    test_dirty_rewrite();
`else
    test_alternate();
`endif
    test_reset_mid_row();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
